// File: rtl/fifo_row_reader.sv
// Reads ROW_WORDS words from a FIFO and presents them as one packed row,
// repeating for num_rows rows; abort flushes the FIFO and drops the transfer.
module fifo_row_reader #(
   parameter int WIDTH     = 32,
   parameter int ROW_WORDS = 4,
   parameter int CNT_W     = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       start,
   input  logic [CNT_W-1:0]           num_rows,
   input  logic                       abort,
   input  logic                       fifo_empty,
   input  logic [WIDTH-1:0]           fifo_dout,
   output logic                       fifo_read_en,
   output logic                       fifo_clear,
   output logic [WIDTH*ROW_WORDS-1:0] row_data,
   output logic                       row_valid,
   input  logic                       row_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int WC_W = $clog2(ROW_WORDS + 1);
   localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);
   localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(ROW_WORDS - 1);
   localparam logic [WC_W-1:0]  WC_FULL  = WC_W'(ROW_WORDS);
   localparam logic [CNT_W-1:0] ROWS_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PRESENT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] rows_left;
   logic [WC_W-1:0]  issued_cnt;
   logic [WC_W-1:0]  captured_cnt;
   logic             rd_pend;
   logic [WIDTH-1:0] row_mem [ROW_WORDS];

   logic kill;
   logic capture;
   logic last_cap;
   logic accept;
   logic launch;

   assign kill     = abort && (state != IDLE);
   assign capture  = rd_pend && !kill;
   assign last_cap = capture && (captured_cnt == WC_LAST);
   assign accept   = (state == PRESENT) && row_ready;
   assign launch   = (state == IDLE) && start;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fifo_read_en = 1'b0;
      fifo_clear   = 1'b0;
      row_valid    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = (num_rows == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            fifo_read_en = !fifo_empty && (issued_cnt < WC_FULL);
            if (last_cap) begin
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            row_valid = 1'b1;
            if (row_ready) begin
               state_nxt = (rows_left == ROWS_ONE) ? DONE : FETCH;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // abort wins over every transition; reset wins over abort
      if (kill) begin
         state_nxt    = IDLE;
         fifo_read_en = 1'b0;
         row_valid    = 1'b0;
         done         = 1'b0;
         fifo_clear   = 1'b1;
      end
      if (RST) begin
         fifo_read_en = 1'b0;
         fifo_clear   = 1'b0;
         done         = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || kill) begin
         rows_left    <= '0;
         issued_cnt   <= '0;
         captured_cnt <= '0;
         rd_pend      <= 1'b0;
         for (int k = 0; k < ROW_WORDS; k++) begin
            row_mem[k] <= '0;
         end
      end else begin
         rd_pend <= fifo_read_en;
         if (launch) begin
            rows_left    <= num_rows;
            issued_cnt   <= '0;
            captured_cnt <= '0;
         end else if (accept) begin
            rows_left    <= rows_left - ROWS_ONE;
            issued_cnt   <= '0;
            captured_cnt <= '0;
         end else begin
            if (fifo_read_en) begin
               issued_cnt <= issued_cnt + WC_ONE;
            end
            if (capture) begin
               captured_cnt <= captured_cnt + WC_ONE;
            end
         end
         for (int k = 0; k < ROW_WORDS; k++) begin
            if (capture && (captured_cnt == WC_W'(k))) begin
               row_mem[k] <= fifo_dout;
            end
         end
      end
   end

   for (genvar g = 0; g < ROW_WORDS; g++) begin : g_pack
      assign row_data[g*WIDTH +: WIDTH] = row_mem[g];
   end

endmodule

// File: tb/tb_fifo_row_reader.sv
// Directed bench for fifo_row_reader: FIFO model with one-cycle read
// latency, monitor counters, and hand-computed expected rows.
module tb_fifo_row_reader;

   localparam int WIDTH     = 32;
   localparam int ROW_WORDS = 4;
   localparam int CNT_W     = 8;
   localparam int RW        = WIDTH * ROW_WORDS;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_rows = '0;
   logic             abort = 1'b0;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dout = '0;
   logic             fifo_read_en;
   logic             fifo_clear;
   logic [RW-1:0]    row_data;
   logic             row_valid;
   logic             row_ready = 1'b1;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   fifo_row_reader #(
      .WIDTH(WIDTH),
      .ROW_WORDS(ROW_WORDS),
      .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .start(start),
      .num_rows(num_rows),
      .abort(abort),
      .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout),
      .fifo_read_en(fifo_read_en),
      .fifo_clear(fifo_clear),
      .row_data(row_data),
      .row_valid(row_valid),
      .row_ready(row_ready),
      .busy(busy),
      .done(done)
   );

   always #5 CLK = ~CLK;

   // FIFO model
   logic [WIDTH-1:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge CLK) begin
      if (fifo_clear) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_read_en && !fifo_empty) begin
         fifo_dout <= mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [WIDTH-1:0] v);
      mem[wr_ptr % 64] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   // monitor, sampled mid-cycle
   int rd_cnt = 0;
   int clr_cnt = 0;
   int done_cnt = 0;
   int rv_cnt = 0;
   int viol = 0;
   int run = 0;
   int last_run = 0;

   always @(negedge CLK) begin
      #2;
      if (fifo_clear) clr_cnt = clr_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
      if (row_valid) rv_cnt = rv_cnt + 1;
      if (fifo_read_en && (fifo_empty || !busy)) viol = viol + 1;
      if (fifo_read_en) begin
         rd_cnt = rd_cnt + 1;
         run = run + 1;
      end else begin
         if (run != 0) last_run = run;
         run = 0;
      end
   end

   task automatic chk(input string tag, input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic next;
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_rv(input string tag, output int n);
      n = 0;
      while (!row_valid && n < 40) begin
         @(negedge CLK);
         n = n + 1;
      end
      chk(tag, RW'(row_valid), RW'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int s_rd;
      int s_clr;
      int s_done;
      int s_rv;
      logic [RW-1:0] held;

      // reset
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_busy", RW'(busy), '0);
      chk("rst_valid", RW'(row_valid), '0);
      chk("rst_done", RW'(done), '0);
      chk("rst_rd", RW'(fifo_read_en), '0);
      chk("rst_clr", RW'(fifo_clear), '0);
      chk("rst_data", row_data, '0);

      // single row
      push(32'h10); push(32'h20); push(32'h30); push(32'h40);
      next();
      RST = 1'b0;
      next();
      s_rd = rd_cnt;
      start = 1'b1;
      num_rows = 8'd1;
      next();
      start = 1'b0;
      wait_rv("t1_to", n);
      chk("t1_lat", RW'(n), RW'(ROW_WORDS + 2));
      chk("t1_row", row_data, 128'h00000040_00000030_00000020_00000010);
      chk("t1_rds", RW'(rd_cnt - s_rd), RW'(4));
      chk("t1_run", RW'(last_run), RW'(4));
      @(negedge CLK);
      chk("t1_done", RW'(done), RW'(1));
      @(negedge CLK);
      chk("t1_done_lo", RW'(done), '0);
      chk("t1_idle", RW'(busy), '0);

      // backpressure, two rows
      for (int i = 1; i <= 8; i++) push(WIDTH'(i));
      next();
      s_done = done_cnt;
      row_ready = 1'b0;
      start = 1'b1;
      num_rows = 8'd2;
      next();
      start = 1'b0;
      wait_rv("t2_to", n);
      chk("t2_row0", row_data, 128'h4_00000003_00000002_00000001);
      held = row_data;
      s_rd = rd_cnt;
      repeat (5) @(negedge CLK);
      chk("t2_hold", row_data, held);
      chk("t2_hold_v", RW'(row_valid), RW'(1));
      chk("t2_no_rd", RW'(rd_cnt - s_rd), '0);
      next();
      row_ready = 1'b1;
      next();
      wait_rv("t2_to1", n);
      chk("t2_row1", row_data, 128'h8_00000007_00000006_00000005);
      repeat (3) @(negedge CLK);
      chk("t2_dones", RW'(done_cnt - s_done), RW'(1));
      chk("t2_idle", RW'(busy), '0);

      // empty stall mid-row
      push(32'h1); push(32'h2);
      next();
      s_rd = rd_cnt;
      start = 1'b1;
      num_rows = 8'd1;
      next();
      start = 1'b0;
      repeat (2) @(negedge CLK);
      repeat (2) begin
         @(negedge CLK);
         chk("t3_stall_rd", RW'(fifo_read_en), '0);
         chk("t3_stall_busy", RW'(busy), RW'(1));
      end
      next();
      push(32'h3); push(32'h4);
      wait_rv("t3_to", n);
      chk("t3_row", row_data, 128'h4_00000003_00000002_00000001);
      chk("t3_rds", RW'(rd_cnt - s_rd), RW'(4));
      repeat (2) @(negedge CLK);

      // abort after two captures
      for (int i = 0; i < 8; i++) push(32'hA1 + WIDTH'(i));
      next();
      s_clr = clr_cnt;
      s_done = done_cnt;
      s_rv = rv_cnt;
      start = 1'b1;
      num_rows = 8'd2;
      next();
      start = 1'b0;
      repeat (3) next();
      abort = 1'b1;
      @(negedge CLK);
      chk("t4_clr", RW'(fifo_clear), RW'(1));
      next();
      abort = 1'b0;
      @(negedge CLK);
      chk("t4_idle", RW'(busy), '0);
      chk("t4_clr_lo", RW'(fifo_clear), '0);
      chk("t4_flushed", RW'(fifo_empty), RW'(1));
      chk("t4_clr_cnt", RW'(clr_cnt - s_clr), RW'(1));
      chk("t4_no_done", RW'(done_cnt - s_done), '0);
      chk("t4_no_rv", RW'(rv_cnt - s_rv), '0);
      push(32'hB1); push(32'hB2); push(32'hB3); push(32'hB4);
      next();
      start = 1'b1;
      num_rows = 8'd1;
      next();
      start = 1'b0;
      wait_rv("t4_to", n);
      chk("t4_row", row_data, 128'hB4_000000B3_000000B2_000000B1);
      repeat (3) @(negedge CLK);

      // num_rows = 0
      next();
      s_rd = rd_cnt;
      start = 1'b1;
      num_rows = 8'd0;
      next();
      start = 1'b0;
      @(negedge CLK);
      chk("t5_zero_done", RW'(done), RW'(1));
      @(negedge CLK);
      chk("t5_zero_idle", RW'(busy), '0);
      chk("t5_zero_rds", RW'(rd_cnt - s_rd), '0);

      // start while busy, and start in the DONE cycle
      push(32'hC1); push(32'hC2); push(32'hC3); push(32'hC4);
      next();
      start = 1'b1;
      num_rows = 8'd1;
      next();
      start = 1'b0;
      next();
      start = 1'b1;
      num_rows = 8'd5;
      next();
      start = 1'b0;
      wait_rv("t5_to", n);
      chk("t5_row", row_data, 128'hC4_000000C3_000000C2_000000C1);
      @(negedge CLK);
      chk("t5_done", RW'(done), RW'(1));
      start = 1'b1;
      num_rows = 8'd1;
      next();
      start = 1'b0;
      @(negedge CLK);
      chk("t5_ign_done", RW'(busy), '0);

      // reset during FETCH overrides abort and start
      push(32'hD1); push(32'hD2); push(32'hD3); push(32'hD4);
      next();
      start = 1'b1;
      num_rows = 8'd3;
      next();
      start = 1'b0;
      next();
      s_clr = clr_cnt;
      s_done = done_cnt;
      RST = 1'b1;
      abort = 1'b1;
      start = 1'b1;
      @(negedge CLK);
      chk("t6_clr_in_rst", RW'(fifo_clear), '0);
      next();
      @(negedge CLK);
      chk("t6_busy", RW'(busy), '0);
      chk("t6_rd", RW'(fifo_read_en), '0);
      chk("t6_clr", RW'(fifo_clear), '0);
      chk("t6_valid", RW'(row_valid), '0);
      chk("t6_done", RW'(done), '0);
      chk("t6_data", row_data, '0);
      next();
      chk("t6_clr_cnt", RW'(clr_cnt - s_clr), '0);
      chk("t6_done_cnt", RW'(done_cnt - s_done), '0);
      RST = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rd_violations", RW'(viol), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
